conv_pool_stage: RTL and testbench

- Sits directly downstream of the convolution datapath and consumes its per-clock adder-tree result stream.
- Tracks the position of every window in the raster stream and discards results from windows that straddle the left image edge or the row wrap.
- Applies ReLU to each valid convolution result.
- Performs 2x2 stride-2 max pooling using a half-width line buffer, and emits one pooled value per pool window with its coordinates.

---
 rtl/conv_pool_stage.sv | 145 ++++++++++++++
 tb/tb_conv_pool_stage.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pool_stage.sv
// conv_pool_stage: ReLU plus 2x2 stride-2 max pooling on the raster-ordered
// convolution result stream. It tracks which image pixel each incoming
// result belongs to, drops windows that straddle the left edge or the row
// wrap, and emits one pooled value per pool window with its coordinates.
module conv_pool_stage #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 5,
    parameter int IMAGE_SIZE  = 28,
    localparam int CONV_SIZE  = IMAGE_SIZE - KERNEL_SIZE + 1,
    localparam int POOL_SIZE  = CONV_SIZE / 2,
    localparam int PW         = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_start,
    input  logic signed [DATA_WIDTH-1:0] conv_result,
    output logic signed [DATA_WIDTH-1:0] pool_out,
    output logic                         pool_valid,
    output logic [PW-1:0]                pool_row,
    output logic [PW-1:0]                pool_col,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int CW = $clog2(IMAGE_SIZE);

    // An odd conv map cannot be tiled by 2x2 pool windows.
    generate
        if (CONV_SIZE % 2 != 0) begin : g_bad_size
            $error("conv_pool_stage: IMAGE_SIZE-KERNEL_SIZE+1 must be even");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ARM, RUN, FLUSH} state_t;

    state_t                       state;
    logic [CW-1:0]                row;
    logic [CW-1:0]                col;
    logic signed [DATA_WIDTH-1:0] h;
    logic signed [DATA_WIDTH-1:0] linebuf [POOL_SIZE];

    logic                         sampling;
    logic                         conv_ok;
    logic                         last_pixel;
    logic [CW-1:0]                cr;
    logic [CW-1:0]                cc;
    logic [PW-1:0]                j;
    logic [PW-1:0]                pr;
    logic signed [DATA_WIDTH-1:0] v;
    logic signed [DATA_WIDTH-1:0] m;
    logic signed [DATA_WIDTH-1:0] lb;
    logic signed [DATA_WIDTH-1:0] pooled;

    // Decode the current pixel position into conv/pool coordinates and form
    // the ReLU value and the horizontal and vertical maxima.
    always_comb begin
        // The result for pixel 0 arrives the cycle after frame_start, which
        // is the ARM cycle, so ARM already samples with counters at (0,0).
        sampling   = (state == ARM) || (state == RUN);
        conv_ok    = (row >= CW'(KERNEL_SIZE - 1)) && (col >= CW'(KERNEL_SIZE - 1));
        last_pixel = (row == CW'(IMAGE_SIZE - 1)) && (col == CW'(IMAGE_SIZE - 1));
        cr         = row - CW'(KERNEL_SIZE - 1);
        cc         = col - CW'(KERNEL_SIZE - 1);
        j          = PW'(cc >> 1);
        pr         = PW'(cr >> 1);
        v          = conv_result[DATA_WIDTH-1] ? '0 : conv_result;
        m          = (h > v) ? h : v;
        lb         = linebuf[j];
        pooled     = (lb > m) ? lb : m;
    end

    // Frame FSM, position counters, pooling state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            h          <= '0;
            for (int i = 0; i < POOL_SIZE; i++) linebuf[i] <= '0;
            pool_out   <= '0;
            pool_valid <= 1'b0;
            pool_row   <= '0;
            pool_col   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pool_valid <= 1'b0;
            frame_done <= 1'b0;
            if (frame_start) begin
                // A new frame (or an abort of the current one) discards all
                // partial pooling state and restarts from pixel (0,0).
                state <= ARM;
                busy  <= 1'b1;
                row   <= '0;
                col   <= '0;
                h     <= '0;
                for (int i = 0; i < POOL_SIZE; i++) linebuf[i] <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    ARM, RUN: begin
                        if (conv_ok) begin
                            if (!cc[0]) begin
                                h <= v;
                            end else if (!cr[0]) begin
                                linebuf[j] <= m;
                            end else begin
                                pool_out   <= pooled;
                                pool_row   <= pr;
                                pool_col   <= j;
                                pool_valid <= 1'b1;
                                frame_done <= (pr == PW'(POOL_SIZE - 1)) &&
                                              (j == PW'(POOL_SIZE - 1));
                            end
                        end
                        if (last_pixel) begin
                            row   <= '0;
                            col   <= '0;
                            state <= FLUSH;
                        end else begin
                            state <= RUN;
                            if (col == CW'(IMAGE_SIZE - 1)) begin
                                col <= '0;
                                row <= row + CW'(1);
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                    end
                    FLUSH: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv_pool_stage.sv
// Testbench for conv_pool_stage: drives whole frames of conv results, records
// every output cycle by cycle and compares against a window-level model.
module tb_conv_pool_stage;

    localparam int IMG  = 28;
    localparam int K    = 5;
    localparam int P    = (IMG - K + 1) / 2;
    localparam int MAXC = 1300;

    logic               clk;
    logic               reset;
    logic               frame_start;
    logic signed [15:0] conv_result;
    logic signed [15:0] pool_out;
    logic               pool_valid;
    logic [3:0]         pool_row;
    logic [3:0]         pool_col;
    logic               busy;
    logic               frame_done;

    int checks;
    int failures;

    logic [15:0] stim      [MAXC];
    logic        obs_valid [MAXC];
    logic        obs_done  [MAXC];
    logic        obs_busy  [MAXC];
    logic [15:0] obs_out   [MAXC];
    logic [3:0]  obs_row   [MAXC];
    logic [3:0]  obs_col   [MAXC];
    logic        exp_valid [MAXC];
    logic        exp_done  [MAXC];
    logic        exp_busy  [MAXC];
    logic [15:0] exp_out   [MAXC];
    logic [3:0]  exp_row   [MAXC];
    logic [3:0]  exp_col   [MAXC];

    conv_pool_stage #(.DATA_WIDTH(16), .KERNEL_SIZE(K), .IMAGE_SIZE(IMG)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .conv_result (conv_result),
        .pool_out    (pool_out),
        .pool_valid  (pool_valid),
        .pool_row    (pool_row),
        .pool_col    (pool_col),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int relu(input logic [15:0] x);
        return x[15] ? 0 : int'(x);
    endfunction

    task automatic clear_model();
        for (int k = 0; k < MAXC; k++) begin
            exp_valid[k] = 1'b0;
            exp_done[k]  = 1'b0;
            exp_busy[k]  = 1'b0;
            exp_out[k]   = '0;
            exp_row[k]   = '0;
            exp_col[k]   = '0;
        end
    endtask

    // Frame started at cycle 'start'; the result for pixel p is stim[start+p+1].
    // Each pool output is the max of the four ReLU'd conv values of its window
    // and appears two cycles after its bottom-right pixel. Nothing after 'stop'.
    task automatic build_model(input int start, input int stop);
        for (int i = 0; i < P; i++) begin
            for (int jj = 0; jj < P; jj++) begin
                int best;
                int cyc;
                best = 0;
                for (int dy = 0; dy < 2; dy++) begin
                    for (int dx = 0; dx < 2; dx++) begin
                        int p;
                        p = (2 * i + dy + K - 1) * IMG + (2 * jj + dx + K - 1);
                        if (relu(stim[start + p + 1]) > best) best = relu(stim[start + p + 1]);
                    end
                end
                cyc = start + (2 * i + K) * IMG + (2 * jj + K) + 2;
                if (cyc <= stop && cyc < MAXC) begin
                    exp_valid[cyc] = 1'b1;
                    exp_out[cyc]   = 16'(best);
                    exp_row[cyc]   = 4'(i);
                    exp_col[cyc]   = 4'(jj);
                    exp_done[cyc]  = (i == P - 1) && (jj == P - 1);
                end
            end
        end
        for (int c = start + 1; c <= start + IMG * IMG + 1; c++) begin
            if (c <= stop && c < MAXC) exp_busy[c] = 1'b1;
        end
    endtask

    // Drives stim[] for n cycles (frame_start at 0 and at fs2, reset for two
    // cycles from rst_at) and records the outputs seen in each cycle.
    task automatic drive(input int n, input int fs2, input int rst_at);
        for (int k = 0; k < n; k++) begin
            frame_start = (k == 0) || (k == fs2);
            conv_result = stim[k];
            reset       = (rst_at >= 0) && (k >= rst_at) && (k < rst_at + 2);
            @(negedge clk);
            obs_valid[k] = pool_valid;
            obs_done[k]  = frame_done;
            obs_busy[k]  = busy;
            obs_out[k]   = pool_out;
            obs_row[k]   = pool_row;
            obs_col[k]   = pool_col;
            @(posedge clk);
            #1;
        end
        frame_start = 1'b0;
        reset       = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({pool_valid, busy, frame_done, pool_out, pool_row, pool_col} !== 27'd0) begin
            failures++;
            $display("[TB] FAIL reset_state got v=%b b=%b d=%b out=%h r=%0d c=%0d want all 0",
                     pool_valid, busy, frame_done, pool_out, pool_row, pool_col);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || pool_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_after_reset got busy=%b valid=%b want 0 0", busy, pool_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_constant();
        int cnt;
        for (int k = 0; k < MAXC; k++) stim[k] = 16'h0100;
        clear_model();
        build_model(0, MAXC);
        drive(800, -1, -1);
        cnt = 0;
        for (int k = 0; k < 800; k++) begin
            cnt += int'(obs_valid[k]);
            checks++;
            if (obs_valid[k] !== exp_valid[k] || obs_done[k] !== exp_done[k] || obs_busy[k] !== exp_busy[k]) begin
                failures++;
                $display("[TB] FAIL const_ctrl cycle=%0d got v/d/b=%b%b%b want %b%b%b", k,
                         obs_valid[k], obs_done[k], obs_busy[k], exp_valid[k], exp_done[k], exp_busy[k]);
            end
            if (exp_valid[k]) begin
                checks++;
                if (obs_out[k] !== exp_out[k] || obs_row[k] !== exp_row[k] || obs_col[k] !== exp_col[k]) begin
                    failures++;
                    $display("[TB] FAIL const_data cycle=%0d got %h(%0d,%0d) want %h(%0d,%0d)", k,
                             obs_out[k], obs_row[k], obs_col[k], exp_out[k], exp_row[k], exp_col[k]);
                end
            end
        end
        checks++;
        if (cnt !== 144) begin
            failures++;
            $display("[TB] FAIL const_count got %0d want 144", cnt);
        end
        checks++;
        if (obs_valid[147] !== 1'b1 || obs_row[147] !== 4'd0 || obs_col[147] !== 4'd0 || obs_out[147] !== 16'h0100) begin
            failures++;
            $display("[TB] FAIL const_first got v=%b (%0d,%0d) %h want 1 (0,0) 0100",
                     obs_valid[147], obs_row[147], obs_col[147], obs_out[147]);
        end
        checks++;
        if (obs_valid[785] !== 1'b1 || obs_done[785] !== 1'b1 || obs_row[785] !== 4'd11 || obs_col[785] !== 4'd11) begin
            failures++;
            $display("[TB] FAIL const_last got v=%b d=%b (%0d,%0d) want 1 1 (11,11)",
                     obs_valid[785], obs_done[785], obs_row[785], obs_col[785]);
        end
        checks++;
        if (obs_busy[1] !== 1'b1 || obs_busy[785] !== 1'b1 || obs_busy[786] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL const_busy got b1=%b b785=%b b786=%b want 1 1 0",
                     obs_busy[1], obs_busy[785], obs_busy[786]);
        end
        checks++;
        if (obs_valid[148] !== 1'b0 || obs_out[148] !== 16'h0100 || obs_col[148] !== 4'd0) begin
            failures++;
            $display("[TB] FAIL const_hold got v=%b out=%h col=%0d want 0 0100 0",
                     obs_valid[148], obs_out[148], obs_col[148]);
        end
    endtask

    task automatic test_pattern(input int kind);
        // kind 0: all negative, 1: ramp, 2: single spike, 3: random
        for (int k = 0; k < MAXC; k++) begin
            case (kind)
                0:       stim[k] = 16'hFF00;
                1:       stim[k] = 16'(k);
                2:       stim[k] = (k == 175) ? 16'h7FFF : 16'h0000;
                default: stim[k] = 16'($urandom);
            endcase
        end
        clear_model();
        build_model(0, MAXC);
        drive(800, -1, -1);
        for (int k = 0; k < 800; k++) begin
            checks++;
            if (obs_valid[k] !== exp_valid[k] || obs_done[k] !== exp_done[k] || obs_busy[k] !== exp_busy[k]) begin
                failures++;
                $display("[TB] FAIL pattern%0d_ctrl cycle=%0d got v/d/b=%b%b%b want %b%b%b", kind, k,
                         obs_valid[k], obs_done[k], obs_busy[k], exp_valid[k], exp_done[k], exp_busy[k]);
            end
            if (exp_valid[k]) begin
                checks++;
                if (obs_out[k] !== exp_out[k] || obs_row[k] !== exp_row[k] || obs_col[k] !== exp_col[k]) begin
                    failures++;
                    $display("[TB] FAIL pattern%0d_data cycle=%0d got %h(%0d,%0d) want %h(%0d,%0d)", kind, k,
                             obs_out[k], obs_row[k], obs_col[k], exp_out[k], exp_row[k], exp_col[k]);
                end
            end
        end
        if (kind == 1) begin
            checks++;
            if (obs_out[147] !== 16'd146) begin
                failures++;
                $display("[TB] FAIL ramp_first got %0d want 146", obs_out[147]);
            end
        end
        if (kind == 2) begin
            checks++;
            if (obs_valid[205] !== 1'b1 || obs_out[205] !== 16'h7FFF || obs_row[205] !== 4'd1 || obs_col[205] !== 4'd1) begin
                failures++;
                $display("[TB] FAIL spike_hit got v=%b %h (%0d,%0d) want 1 7fff (1,1)",
                         obs_valid[205], obs_out[205], obs_row[205], obs_col[205]);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < MAXC; k++) stim[k] = 16'($urandom);
        clear_model();
        build_model(0, 299);
        drive(320, -1, 300);
        for (int k = 0; k < 320; k++) begin
            checks++;
            if (obs_valid[k] !== exp_valid[k] || obs_done[k] !== exp_done[k] || obs_busy[k] !== exp_busy[k]) begin
                failures++;
                $display("[TB] FAIL rstmid_ctrl cycle=%0d got v/d/b=%b%b%b want %b%b%b", k,
                         obs_valid[k], obs_done[k], obs_busy[k], exp_valid[k], exp_done[k], exp_busy[k]);
            end
            if (exp_valid[k]) begin
                checks++;
                if (obs_out[k] !== exp_out[k] || obs_row[k] !== exp_row[k] || obs_col[k] !== exp_col[k]) begin
                    failures++;
                    $display("[TB] FAIL rstmid_data cycle=%0d got %h(%0d,%0d) want %h(%0d,%0d)", k,
                             obs_out[k], obs_row[k], obs_col[k], exp_out[k], exp_row[k], exp_col[k]);
                end
            end
        end
        checks++;
        if (obs_out[300] !== 16'h0000 || obs_out[319] !== 16'h0000 || obs_row[300] !== 4'd0) begin
            failures++;
            $display("[TB] FAIL rstmid_zero got out300=%h out319=%h row300=%0d want 0 0 0",
                     obs_out[300], obs_out[319], obs_row[300]);
        end
        // A fresh frame after the reset must be complete and correct.
        test_pattern(3);
    endtask

    task automatic test_restart();
        int dones;
        for (int k = 0; k < MAXC; k++) stim[k] = 16'($urandom);
        clear_model();
        build_model(0, 400);
        build_model(400, MAXC);
        drive(1200, 400, -1);
        dones = 0;
        for (int k = 0; k < 1200; k++) begin
            dones += int'(obs_done[k]);
            checks++;
            if (obs_valid[k] !== exp_valid[k] || obs_done[k] !== exp_done[k] || obs_busy[k] !== exp_busy[k]) begin
                failures++;
                $display("[TB] FAIL restart_ctrl cycle=%0d got v/d/b=%b%b%b want %b%b%b", k,
                         obs_valid[k], obs_done[k], obs_busy[k], exp_valid[k], exp_done[k], exp_busy[k]);
            end
            if (exp_valid[k]) begin
                checks++;
                if (obs_out[k] !== exp_out[k] || obs_row[k] !== exp_row[k] || obs_col[k] !== exp_col[k]) begin
                    failures++;
                    $display("[TB] FAIL restart_data cycle=%0d got %h(%0d,%0d) want %h(%0d,%0d)", k,
                             obs_out[k], obs_row[k], obs_col[k], exp_out[k], exp_row[k], exp_col[k]);
                end
            end
        end
        checks++;
        if (dones !== 1 || obs_done[1185] !== 1'b1 || obs_busy[1186] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL restart_done got count=%0d d1185=%b b1186=%b want 1 1 0",
                     dones, obs_done[1185], obs_busy[1186]);
        end
        checks++;
        if (obs_valid[547] !== 1'b1 || obs_row[547] !== 4'd0 || obs_col[547] !== 4'd0) begin
            failures++;
            $display("[TB] FAIL restart_first got v=%b (%0d,%0d) want 1 (0,0)",
                     obs_valid[547], obs_row[547], obs_col[547]);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        frame_start = 1'b0;
        conv_result = '0;
        test_reset();
        test_constant();
        test_pattern(0);
        test_pattern(1);
        test_pattern(2);
        test_pattern(3);
        test_reset_mid();
        test_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
